// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a fixed-length burst from a first-word-fall-through
// FIFO and replays it on a registered valid/ready stream. m_last marks the
// final beat, and done pulses one cycle after that beat is accepted.
module fifo_burst_reader #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  localparam int LW     = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LW-1:0]    len,
  output logic             busy,
  output logic             done,
  output logic             fifo_ren,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_valid,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   rem, rem_nxt;
  logic [LW-1:0]   len_clamped;
  logic            slot_free;
  logic            accept;
  logic            done_nxt;

  // A request longer than the burst limit is silently trimmed to MAX_LEN.
  assign len_clamped = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;

  // The output register can take a new word when it is empty or draining now.
  assign slot_free = !m_valid || m_ready;
  assign accept    = m_valid && m_ready;
  assign busy      = (state != IDLE);

  // State and remaining-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Next-state logic and the combinational FIFO pop. The pop is held off
  // while rst is high so a reset never consumes a word it will then drop.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    done_nxt  = 1'b0;
    fifo_ren  = !rst && (state == READ) && (rem != '0) && fifo_valid && slot_free;
    case (state)
      IDLE: begin
        if (start) begin
          rem_nxt = len_clamped;
          if (len_clamped == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ: begin
        if (fifo_ren) begin
          rem_nxt = rem - 1'b1;
          if (rem == LW'(1)) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (accept && m_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output beat register: load on pop, clear valid on a bare accept, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (fifo_ren) begin
      m_valid <= 1'b1;
      m_data  <= fifo_data;
      m_last  <= (rem == LW'(1));
    end else if (accept) begin
      m_valid <= 1'b0;
    end
  end

  // Completion pulse, registered so it lands the cycle after the triggering edge.
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= done_nxt;
  end

endmodule
